tm1638_refresh_ctrl: RTL
========================

TM1638_REFRESH_CTRL -- requirements
Module: tm1638_refresh_ctrl

Interface
REQ-001 SHALL have parameter REFRESH_CYCLES, default 0; auto-refresh period in clocks, 0 = auto-refresh disabled.
REQ-002 SHALL have port i_Clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port i_Rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_Refresh  input  1  one-cycle request to send a full display update.
REQ-005 SHALL have port i_Wr_En  input  1  display buffer write strobe.
REQ-006 SHALL have port i_Wr_Addr  input  4  display buffer byte address 0..15.
REQ-007 SHALL have port i_Wr_Data  input  8  display buffer byte.
REQ-008 SHALL have port i_Display_On  input  1  display enable bit for the control command.
REQ-009 SHALL have port i_Brightness  input  3  brightness level for the control command.
REQ-010 SHALL have port i_FIFO_Full  input  1  downstream spi_fifo full flag.
REQ-011 SHALL have port o_Data_Valid  output  1  word push strobe to spi_fifo.
REQ-012 SHALL have port o_Data  output  18  word to spi_fifo: [17] = end-of-frame (STB released after this byte), [16:8] = 0, [7:0] = byte.
REQ-013 SHALL have port o_Busy  output  1  high while an update is in progress.
REQ-014 SHALL have port o_Done  output  1  one-cycle pulse after the last word of an update is accepted.

Function
REQ-015 SHALL hold a 16 x 8 display buffer; a write with i_Wr_En=1 updates the addressed byte on the next edge, in any state.
REQ-016 SHALL implement states IDLE, CMD_MODE, CMD_ADDR, DATA, CMD_CTRL, DONE.
REQ-017 SHALL leave IDLE for CMD_MODE on the edge where i_Refresh=1, pending=1 or the auto-refresh timer expires.
REQ-018 SHALL push 19 words per update, in order: {1,0x40}; {0,0xC0}; buffer[0..14] with [17]=0; buffer[15] with [17]=1; {1, 0x80 | i_Display_On<<3 | i_Brightness}.
REQ-019 SHALL drive o_Data_Valid = 1 only in CMD_MODE, CMD_ADDR, DATA and CMD_CTRL, and only when i_FIFO_Full = 0 (combinational gate).
REQ-020 SHALL treat a word as accepted on each edge where o_Data_Valid=1; advance the word index/state only on acceptance; hold o_Data stable while stalled.
REQ-021 SHALL allow back-to-back acceptance, one word per clock, while i_FIFO_Full=0.
REQ-022 SHALL use a 4-bit byte index in DATA; leave DATA for CMD_CTRL after index 15 is accepted; the index never wraps within an update.
REQ-023 SHALL sample buffer bytes and control bits at the cycle each word is presented, not at update start.
REQ-024 SHALL set pending on i_Refresh, i_Wr_En or any i_Display_On/i_Brightness change while not in IDLE; clear pending when entering CMD_MODE.
REQ-025 SHALL go DONE -> IDLE in one cycle with o_Done=1 during DONE; if pending=1, IDLE immediately restarts the next edge.
REQ-026 SHALL count IDLE cycles when REFRESH_CYCLES>0, start an update when the count reaches REFRESH_CYCLES-1, and clear the count on leaving IDLE.
REQ-027 SHALL ignore i_Refresh in IDLE when an auto-refresh start coincides (single update, no pending set).
REQ-028 SHALL drive o_Busy = 1 in every state except IDLE.

Reset
REQ-029 SHALL on i_Rst=1: state IDLE, buffer all 0x00, pending 0, timer 0, index 0; o_Data_Valid 0, o_Data 0, o_Busy 0, o_Done 0.
REQ-030 SHALL abort an in-progress update on reset with no further pushes; a partial frame is not completed.

Verification
REQ-031 SHALL cover: write buffer[i]=i+1, i_Refresh pulse, FIFO never full -> 19 consecutive pushes 0x20040? no: {1,40},{0,C0},01..10 with [17] only on 0x10, then {1,0x8F} for On=1, Bright=7; o_Done pulses once.
REQ-032 SHALL cover: i_FIFO_Full toggled 1 of every 2 cycles -> o_Data_Valid never high while full, same 19-word sequence, no word duplicated or dropped.
REQ-033 SHALL cover: i_Wr_En addr 3 during DATA index 8 -> current update completes, second full update starts the cycle after DONE->IDLE with new byte.
REQ-034 SHALL cover: REFRESH_CYCLES=10, no requests -> update starts every 10 idle cycles after previous o_Done.
REQ-035 SHALL cover: i_Rst asserted during DATA index 5 -> next cycle o_Data_Valid=0, o_Busy=0, buffer reads 0x00 on following update.

Source files
------------

// File: rtl/tm1638_refresh_ctrl.sv
// rtl/tm1638_refresh_ctrl.sv - TM1638 display refresh sequencer feeding an SPI word FIFO
//
// Ports:
//   i_Clk, i_Rst        clock, synchronous active-high reset
//   i_Refresh           one-cycle request for a full display update
//   i_Wr_En/Addr/Data   display buffer byte write (16 x 8)
//   i_Display_On        display enable bit for the control command
//   i_Brightness        brightness level for the control command
//   i_FIFO_Full         downstream FIFO full flag
//   o_Data_Valid        word push strobe (gated by i_FIFO_Full)
//   o_Data              {end_of_frame, 9'b0, byte}
//   o_Busy              update in progress
//   o_Done              one-cycle pulse when an update has finished
module tm1638_refresh_ctrl #(
  parameter int unsigned REFRESH_CYCLES = 0
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Refresh,
  input  logic        i_Wr_En,
  input  logic [3:0]  i_Wr_Addr,
  input  logic [7:0]  i_Wr_Data,
  input  logic        i_Display_On,
  input  logic [2:0]  i_Brightness,
  input  logic        i_FIFO_Full,
  output logic        o_Data_Valid,
  output logic [17:0] o_Data,
  output logic        o_Busy,
  output logic        o_Done
);

  localparam bit          AUTO_EN   = (REFRESH_CYCLES != 0);
  localparam logic [31:0] AUTO_LAST = AUTO_EN ? 32'(REFRESH_CYCLES - 1) : 32'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD_MODE,
    S_CMD_ADDR,
    S_DATA,
    S_CMD_CTRL,
    S_DONE
  } state_t;

  state_t      state_q;
  logic [7:0]  buf_q [16];
  logic [3:0]  idx_q;
  logic        pending_q;
  logic [3:0]  ctrl_prev_q;
  logic [31:0] timer_q;

  logic        pushing;
  logic        accept;
  logic        ctrl_chg;
  logic        auto_fire;
  logic        eof;
  logic [7:0]  byte_sel;

  assign pushing   = (state_q == S_CMD_MODE) || (state_q == S_CMD_ADDR) ||
                     (state_q == S_DATA)     || (state_q == S_CMD_CTRL);
  assign accept    = pushing && !i_FIFO_Full;
  assign ctrl_chg  = ({i_Display_On, i_Brightness} != ctrl_prev_q);
  assign auto_fire = AUTO_EN && (timer_q == AUTO_LAST);

  assign o_Data_Valid = accept;
  assign o_Busy       = (state_q != S_IDLE);
  assign o_Done       = (state_q == S_DONE);

  // Word content is decoded from the current state every cycle, so buffer
  // bytes and control bits reflect their value when the word is presented.
  always_comb begin
    byte_sel = 8'h00;
    eof      = 1'b0;
    case (state_q)
      S_CMD_MODE: begin
        byte_sel = 8'h40;
        eof      = 1'b1;
      end
      S_CMD_ADDR: begin
        byte_sel = 8'hC0;
      end
      S_DATA: begin
        byte_sel = buf_q[idx_q];
        eof      = (idx_q == 4'hF);
      end
      S_CMD_CTRL: begin
        byte_sel = {4'h8, i_Display_On, i_Brightness};
        eof      = 1'b1;
      end
      default: begin
        byte_sel = 8'h00;
        eof      = 1'b0;
      end
    endcase
    o_Data = {eof, 9'b0, byte_sel};
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q     <= S_IDLE;
      idx_q       <= 4'd0;
      pending_q   <= 1'b0;
      timer_q     <= 32'd0;
      ctrl_prev_q <= 4'd0;
      for (int i = 0; i < 16; i++) begin
        buf_q[i] <= 8'h00;
      end
    end else begin
      ctrl_prev_q <= {i_Display_On, i_Brightness};

      if (i_Wr_En) begin
        buf_q[i_Wr_Addr] <= i_Wr_Data;
      end

      // Anything that changes what the display should show during an
      // update queues exactly one follow-up update.
      if ((state_q != S_IDLE) && (i_Refresh || i_Wr_En || ctrl_chg)) begin
        pending_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (i_Refresh || pending_q || auto_fire) begin
            state_q   <= S_CMD_MODE;
            pending_q <= 1'b0;
            timer_q   <= 32'd0;
            idx_q     <= 4'd0;
          end else if (AUTO_EN) begin
            timer_q <= timer_q + 32'd1;
          end
        end
        S_CMD_MODE: begin
          if (accept) state_q <= S_CMD_ADDR;
        end
        S_CMD_ADDR: begin
          if (accept) begin
            state_q <= S_DATA;
            idx_q   <= 4'd0;
          end
        end
        S_DATA: begin
          if (accept) begin
            if (idx_q == 4'hF) begin
              state_q <= S_CMD_CTRL;
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end
        end
        S_CMD_CTRL: begin
          if (accept) state_q <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
